// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared constants for the 6502 bus responder.
//   Vector addresses, timer register offsets, CTRL/STATUS bit indices and
//   wait-FSM state encoding.
package cpu_bus_pkg;
   localparam logic [15:0] VEC_NMI    = 16'hFFFA;
   localparam logic [15:0] VEC_RESET  = 16'hFFFC;
   localparam logic [15:0] VEC_IRQ    = 16'hFFFE;
   localparam logic [1:0]  OFF_RLO    = 2'd0;
   localparam logic [1:0]  OFF_RHI    = 2'd1;
   localparam logic [1:0]  OFF_CTRL   = 2'd2;
   localparam logic [1:0]  OFF_STATUS = 2'd3;
   localparam int          CTRL_EN    = 0;
   localparam int          CTRL_IEN   = 1;
   localparam int          CTRL_AUTO  = 2;
   localparam int          STATUS_EXP = 0;
   localparam logic [0:0]  ST_IDLE    = 1'b0;
   localparam logic [0:0]  ST_WAIT    = 1'b1;
endpackage

// File: rtl/sys_timer.sv
// sys_timer: 16-bit interval timer with reload, control, sticky expiry flag and IRQ.
//   clk   in  1  clock
//   res   in  1  asynchronous reset, active low
//   sel   in  1  register window selected by the current bus address
//   off   in  2  register offset (RLO, RHI, CTRL, STATUS)
//   we    in  1  write strobe, high only on the completing cycle of a write
//   wdata in  8  write data
//   rdata out 8  register read data
//   IRQ   out 1  active-low interrupt request
module sys_timer
   import cpu_bus_pkg::*;
(
   input  logic       clk,
   input  logic       res,
   input  logic       sel,
   input  logic [1:0] off,
   input  logic       we,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       IRQ
);
   logic [7:0]  rlo, rhi;
   logic [15:0] count;
   logic        en, ien, auto, exp, wr;
   assign wr = sel && we;
   assign IRQ = !(exp && ien);
   assign rdata = off == OFF_RLO  ? rlo :
                  off == OFF_RHI  ? rhi :
                  off == OFF_CTRL ? {5'd0, auto, ien, en} : {7'd0, exp};
   // Statement order sets priority: W1C loses to expiry, and register
   // writes (CTRL enable, RHI count load) override the timer's own update.
   always_ff @(posedge clk or negedge res)
      if (!res) begin
         rlo   <= '0;
         rhi   <= '0;
         count <= '0;
         en    <= 1'b0;
         ien   <= 1'b0;
         auto  <= 1'b0;
         exp   <= 1'b0;
      end else begin
         if (wr && off == OFF_STATUS && wdata[STATUS_EXP]) exp <= 1'b0;
         if (en) begin
            if (count > 16'd1) count <= count - 16'd1;
            else begin
               // count==1 steps to 0; a running count of 0 reloads or stops
               exp <= 1'b1;
               if (count == 16'd1) count <= '0;
               else if (auto) count <= {rhi, rlo};
               else en <= 1'b0;
            end
         end
         if (wr && off == OFF_RLO) rlo <= wdata;
         if (wr && off == OFF_RHI) begin
            rhi   <= wdata;
            count <= {wdata, rlo};
         end
         if (wr && off == OFF_CTRL) begin
            en   <= wdata[CTRL_EN];
            ien  <= wdata[CTRL_IEN];
            auto <= wdata[CTRL_AUTO];
         end
      end
endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory/peripheral side of the 6502 bus (RAM, vector ROM, timer, wait states).
//   clk      in  1   CPU clock
//   res      in  1   asynchronous reset, active low
//   add_bus  in  16  CPU address
//   d_wr     in  8   write data from CPU
//   write_en in  1   active low write enable (0 = write)
//   d_rd     out 8   read data to CPU, combinational
//   rdy      out 1   access completes this cycle when high
//   IRQ      out 1   active-low interrupt request
module cpu_bus_responder
   import cpu_bus_pkg::*;
#(
   parameter int          RAM_AW    = 11,
   parameter logic [15:0] IO_BASE   = 16'h4000,
   parameter int          IO_WAIT   = 2,
   parameter logic [15:0] NMI_VEC   = 16'h0200,
   parameter logic [15:0] RESET_VEC = 16'h0200,
   parameter logic [15:0] IRQ_VEC   = 16'h0300
)(
   input  logic        clk,
   input  logic        res,
   input  logic [15:0] add_bus,
   input  logic [7:0]  d_wr,
   input  logic        write_en,
   output logic [7:0]  d_rd,
   output logic        rdy,
   output logic        IRQ
);
   localparam bit STALL = IO_WAIT != 0;
   logic [7:0]  mem [2**RAM_AW];
   logic [0:0]  state;
   logic [7:0]  wcnt;
   logic [15:0] vec;
   logic [7:0]  t_rdata;
   logic        ram_hit, io_hit, vec_hit, wr_ok;
   assign ram_hit = add_bus[15:RAM_AW] == '0;
   assign io_hit  = add_bus[15:2] == IO_BASE[15:2];
   assign vec_hit = add_bus >= VEC_NMI;
   assign vec = add_bus[15:1] == VEC_NMI[15:1]   ? NMI_VEC :
                add_bus[15:1] == VEC_RESET[15:1] ? RESET_VEC : IRQ_VEC;
   // Reset forces rdy high even if the address sits in the I/O window.
   assign rdy = !res || (state == ST_IDLE ? !(io_hit && STALL) : wcnt == 8'd0);
   assign wr_ok = res && rdy && !write_en;
   assign d_rd = ram_hit ? mem[add_bus[RAM_AW-1:0]] :
                 io_hit  ? t_rdata :
                 vec_hit ? (add_bus[0] ? vec[15:8] : vec[7:0]) : 8'hFF;
   always_ff @(posedge clk)
      if (wr_ok && ram_hit) mem[add_bus[RAM_AW-1:0]] <= d_wr;
   always_ff @(posedge clk or negedge res)
      if (!res) begin
         state <= ST_IDLE;
         wcnt  <= '0;
      end else if (state == ST_IDLE) begin
         if (io_hit && STALL) begin
            state <= ST_WAIT;
            wcnt  <= 8'(IO_WAIT - 1);
         end
      end else if (wcnt != 8'd0) wcnt <= wcnt - 8'd1;
      else state <= ST_IDLE;
   sys_timer u_timer (
      .clk   (clk),
      .res   (res),
      .sel   (io_hit),
      .off   (add_bus[1:0]),
      .we    (wr_ok),
      .wdata (d_wr),
      .rdata (t_rdata),
      .IRQ   (IRQ)
   );
endmodule
